biu_arbiter: RTL

//  Shares the single bus interface unit (biu) between the fetch control unit (fcu, instruction

---
 rtl/biu_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/biu_arbiter.sv
// Arbitrates the single bus interface unit between fetch (fcu) and execution (eu) units.
// EU has priority, a starvation counter forces fetch progress, a watchdog aborts hung transfers.
module biu_arbiter #(
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 4,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_fcu,
  input  logic [SEL_W-1:0] sel_fcu_in,
  input  logic             req_eu,
  input  logic [SEL_W-1:0] sel_eu_in,
  input  logic             ready_bus,
  output logic             cs_biu,
  output logic [SEL_W-1:0] sel_biu,
  output logic             gnt_fcu,
  output logic             gnt_eu,
  output logic             done_fcu,
  output logic             done_eu,
  output logic             timeout_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GNT_FCU, GNT_EU, TURN} state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM  = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cs_q, cs_d;
  logic             gnt_fcu_q, gnt_fcu_d;
  logic             gnt_eu_q, gnt_eu_d;
  logic             done_fcu_q, done_fcu_d;
  logic             done_eu_q, done_eu_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             req_own;

  function automatic logic [CNT_W-1:0] starve_sat_inc(input logic [CNT_W-1:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    wdog_d     = wdog_q;
    sel_d      = sel_q;
    done_fcu_d = 1'b0;
    done_eu_d  = 1'b0;
    err_d      = 1'b0;
    wdog_inc   = wdog_q + 1'b1;
    req_own    = (state_q == GNT_FCU) ? req_fcu : req_eu;

    case (state_q)
      IDLE: begin
        if (req_fcu && (starve_q == STARVE_LIM)) begin
          state_d  = GNT_FCU;
          sel_d    = sel_fcu_in;
          starve_d = '0;
          wdog_d   = '0;
        end else if (req_eu) begin
          state_d = GNT_EU;
          sel_d   = sel_eu_in;
          wdog_d  = '0;
          if (req_fcu) starve_d = starve_sat_inc(starve_q);
        end else if (req_fcu) begin
          state_d  = GNT_FCU;
          sel_d    = sel_fcu_in;
          starve_d = '0;
          wdog_d   = '0;
        end
      end
      GNT_FCU, GNT_EU: begin
        // wdog_inc counts the current grant cycle, so the abort lands on grant cycle TIMEOUT
        wdog_d = wdog_inc;
        if (ready_bus) begin
          state_d    = TURN;
          done_fcu_d = (state_q == GNT_FCU);
          done_eu_d  = (state_q == GNT_EU);
        end else if (!req_own) begin
          state_d = IDLE;
        end else if (wdog_inc == TIMEOUT_LIM) begin
          state_d = TURN;
          err_d   = 1'b1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d      = (state_d == GNT_FCU) || (state_d == GNT_EU);
    gnt_fcu_d = (state_d == GNT_FCU);
    gnt_eu_d  = (state_d == GNT_EU);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      wdog_q     <= '0;
      sel_q      <= '0;
      cs_q       <= 1'b0;
      gnt_fcu_q  <= 1'b0;
      gnt_eu_q   <= 1'b0;
      done_fcu_q <= 1'b0;
      done_eu_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wdog_q     <= wdog_d;
      sel_q      <= sel_d;
      cs_q       <= cs_d;
      gnt_fcu_q  <= gnt_fcu_d;
      gnt_eu_q   <= gnt_eu_d;
      done_fcu_q <= done_fcu_d;
      done_eu_q  <= done_eu_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign cs_biu      = cs_q;
  assign sel_biu     = sel_q;
  assign gnt_fcu     = gnt_fcu_q;
  assign gnt_eu      = gnt_eu_q;
  assign done_fcu    = done_fcu_q;
  assign done_eu     = done_eu_q;
  assign timeout_err = err_q;
  assign busy        = busy_q;

endmodule
